// File: rtl/packet_forwarder.sv
// Drains one packet from packet memory and emits it as an AXI-Stream master.
// A 2-entry skid buffer absorbs the 1-cycle read latency under tready backpressure.

module packet_forwarder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [ADDR_WIDTH-1:0]     forwarder_rd_addr,
  input  logic [DATA_WIDTH-1:0]     forwarder_rd_data,
  output logic                      forwarder_rd_en,
  output logic                      forwarder_done,
  input  logic                      ready_for_forwarder,
  input  logic [ADDR_WIDTH:0]       len_to_forwarder,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [31:0]               pkt_count
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE,
    S_COOLDOWN
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_done;
  logic [31:0]           r_pkt_count;

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [DATA_WIDTH-1:0] r_tail_data;
  logic                  r_head_last;
  logic                  r_tail_last;

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_level;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_issue_last;
  logic [LEN_WIDTH-1:0]  w_len_clamped;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_pop         = (r_occ != 2'd0) && m_axis_tready;
    w_push        = r_inflight;
    // Entries that will be held after this edge; a new read may only issue if
    // that leaves a free slot for its data one cycle later.
    w_level       = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_room        = (w_level <= 3'd1);
    w_issue       = (r_state == S_READ) && (r_cnt < r_len) && w_room;
    w_issue_last  = (r_cnt == (r_len - LEN_WIDTH'(1)));
    w_len_clamped = (len_to_forwarder > MAX_LEN) ? MAX_LEN : len_to_forwarder;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_len           <= '0;
      r_cnt           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_pkt_count     <= '0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_issue_last;
      case (r_state)
        S_IDLE: begin
          if (ready_for_forwarder) begin
            r_len <= w_len_clamped;
            r_cnt <= '0;
            if (w_len_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_cnt <= r_cnt + LEN_WIDTH'(1);
            if (w_issue_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && r_head_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_pkt_count <= r_pkt_count + 32'd1;
          r_state     <= S_COOLDOWN;
        end
        S_COOLDOWN: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the skid data registers are reset as well, because tdata must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ       <= 2'd0;
      r_head_data <= '0;
      r_tail_data <= '0;
      r_head_last <= 1'b0;
      r_tail_last <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head_data <= forwarder_rd_data;
            r_head_last <= r_inflight_last;
          end else begin
            r_tail_data <= forwarder_rd_data;
            r_tail_last <= r_inflight_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head_data <= r_tail_data;
          r_head_last <= r_tail_last;
          r_occ       <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head_data <= forwarder_rd_data;
            r_head_last <= r_inflight_last;
          end else begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
            r_tail_data <= forwarder_rd_data;
            r_tail_last <= r_inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign forwarder_rd_en   = w_issue;
  assign forwarder_rd_addr = r_cnt[ADDR_WIDTH-1:0];
  assign forwarder_done    = r_done;
  assign pkt_count         = r_pkt_count;
  assign m_axis_tvalid     = (r_occ != 2'd0);
  assign m_axis_tdata      = r_head_data;
  assign m_axis_tlast      = m_axis_tvalid & r_head_last;
  assign m_axis_tkeep      = {KEEP_WIDTH{m_axis_tvalid}};

endmodule

// File: tb/tb_packet_forwarder.sv
// Directed bench for packet_forwarder: memory model returns addr+base one cycle after rd_en;
// a negedge monitor logs beats, reads, done pulses and protocol violations for the test tasks.

module tb_packet_forwarder;

  localparam int DW = 64;
  localparam int AW = 9;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic          done;
  logic          ready;
  logic [LW-1:0] len;
  logic [DW-1:0] tdata;
  logic [7:0]    tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [31:0]   pkt_count;
  logic [DW-1:0] data_base;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] beat_data [1024];
  bit            beat_last [1024];
  int            beat_cyc  [1024];
  int            read_addr [1024];
  int            done_cyc  [16];
  int            n_beats = 0, n_reads = 0, n_done = 0, n_valid = 0;
  int            stall_viol = 0, ahead_viol = 0, keep_viol = 0;
  int            outstanding = 0, nxt_out;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  packet_forwarder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .forwarder_rd_addr   (rd_addr),
    .forwarder_rd_data   (rd_data),
    .forwarder_rd_en     (rd_en),
    .forwarder_done      (done),
    .ready_for_forwarder (ready),
    .len_to_forwarder    (len),
    .m_axis_tdata        (tdata),
    .m_axis_tkeep        (tkeep),
    .m_axis_tlast        (tlast),
    .m_axis_tvalid       (tvalid),
    .m_axis_tready       (tready),
    .pkt_count           (pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr) + data_base;

  always_comb nxt_out = outstanding + (rd_en ? 1 : 0) - ((tvalid && tready) ? 1 : 0);

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding <= 0;
      prev_stall  <= 1'b0;
    end else begin
      outstanding <= nxt_out;
      if (nxt_out > 2) ahead_viol <= ahead_viol + 1;
      if (tvalid ? (tkeep !== 8'hFF) : (tkeep !== 8'h00)) keep_viol <= keep_viol + 1;
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last))
        stall_viol <= stall_viol + 1;
      if (tvalid) n_valid <= n_valid + 1;
      if (rd_en && n_reads < 1024) begin
        read_addr[n_reads] <= int'(rd_addr);
        n_reads <= n_reads + 1;
      end
      if (tvalid && tready && n_beats < 1024) begin
        beat_data[n_beats] <= tdata;
        beat_last[n_beats] <= tlast;
        beat_cyc[n_beats]  <= cyc;
        n_beats <= n_beats + 1;
      end
      if (done && n_done < 16) begin
        done_cyc[n_done] <= cyc;
        n_done <= n_done + 1;
      end
      prev_stall <= tvalid && !tready;
      prev_data  <= tdata;
      prev_last  <= tlast;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < budget) begin
      step();
      if (n_done > target) ok = 1'b1;
      i++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step(2);
    checks++; if (tvalid !== 1'b0)   begin errors++; $display("FAIL reset_tvalid got=%0b exp=0", tvalid); end
    checks++; if (tdata !== '0)      begin errors++; $display("FAIL reset_tdata got=%0h exp=0", tdata); end
    checks++; if (tkeep !== 8'h00)   begin errors++; $display("FAIL reset_tkeep got=%0h exp=0", tkeep); end
    checks++; if (tlast !== 1'b0)    begin errors++; $display("FAIL reset_tlast got=%0b exp=0", tlast); end
    checks++; if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en); end
    checks++; if (rd_addr !== '0)    begin errors++; $display("FAIL reset_rd_addr got=%0h exp=0", rd_addr); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (pkt_count !== '0)  begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
    rst_n = 1'b1;
    step(2);
    checks++; if (rd_en !== 1'b0 || tvalid !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got=rd_en:%0b,tvalid:%0b exp=0,0", rd_en, tvalid);
    end
  endtask

  task automatic test_len4();
    int n, b0, d0;
    bit ok;
    tready = 1'b1; data_base = 64'h100;
    b0 = n_beats; d0 = n_done;
    len = 10'd4; ready = 1'b1; n = cyc;
    wait_done(d0, 40, ok);
    ready = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL len4_done_timeout got=%0b exp=1", ok); end
    checks++; if (n_beats - b0 !== 4) begin errors++; $display("FAIL len4_beats got=%0d exp=4", n_beats - b0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_data[b0+i] !== 64'h100 + 64'(i)) begin
        errors++; $display("FAIL len4_data[%0d] got=%0h exp=%0h", i, beat_data[b0+i], 64'h100 + 64'(i));
      end
      checks++; if (beat_cyc[b0+i] !== n + 3 + i) begin
        errors++; $display("FAIL len4_cycle[%0d] got=%0d exp=%0d", i, beat_cyc[b0+i], n + 3 + i);
      end
      checks++; if (beat_last[b0+i] !== (i == 3)) begin
        errors++; $display("FAIL len4_tlast[%0d] got=%0b exp=%0b", i, beat_last[b0+i], i == 3);
      end
    end
    checks++; if (done_cyc[d0] !== n + 7) begin errors++; $display("FAIL len4_done_cycle got=%0d exp=%0d", done_cyc[d0], n + 7); end
    step(2);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL len4_done_pulses got=%0d exp=1", n_done - d0); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL len4_pkt_count got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_backpressure();
    int b0, d0, sv0, av0, kv0, k;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    data_base = 64'h100;
    b0 = n_beats; d0 = n_done; sv0 = stall_viol; av0 = ahead_viol; kv0 = keep_viol;
    len = 10'd8; ready = 1'b1; tready = pat[0];
    k = 1;
    while (n_done <= d0 && k < 100) begin
      step();
      tready = pat[k % 4];
      k++;
    end
    ready = 1'b0; tready = 1'b1;
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", n_done - d0); end
    checks++; if (n_beats - b0 !== 8) begin errors++; $display("FAIL bp_beats got=%0d exp=8", n_beats - b0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (beat_data[b0+i] !== 64'h100 + 64'(i) || beat_last[b0+i] !== (i == 7)) begin
        errors++; $display("FAIL bp_beat[%0d] got=%0h/%0b exp=%0h/%0b", i, beat_data[b0+i], beat_last[b0+i],
                           64'h100 + 64'(i), i == 7);
      end
    end
    checks++; if (stall_viol - sv0 !== 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol - sv0); end
    checks++; if (ahead_viol - av0 !== 0) begin errors++; $display("FAIL bp_reads_ahead got=%0d exp=0", ahead_viol - av0); end
    checks++; if (keep_viol - kv0 !== 0)  begin errors++; $display("FAIL bp_tkeep got=%0d exp=0", keep_viol - kv0); end
    step(2);
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL bp_pkt_count got=%0d exp=2", pkt_count); end
  endtask

  task automatic test_zero_len();
    int n, b0, d0, v0, r0;
    bit ok;
    b0 = n_beats; d0 = n_done; v0 = n_valid; r0 = n_reads;
    len = 10'd0; ready = 1'b1; n = cyc;
    wait_done(d0, 20, ok);
    ready = 1'b0;
    step(3);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_done_timeout got=%0b exp=1", ok); end
    checks++; if (done_cyc[d0] !== n + 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc[d0], n + 1); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", n_done - d0); end
    checks++; if (n_valid - v0 !== 0 || n_beats - b0 !== 0) begin
      errors++; $display("FAIL zero_no_beats got=valid:%0d,beats:%0d exp=0,0", n_valid - v0, n_beats - b0);
    end
    checks++; if (n_reads - r0 !== 0) begin errors++; $display("FAIL zero_no_reads got=%0d exp=0", n_reads - r0); end
    checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL zero_pkt_count got=%0d exp=3", pkt_count); end
  endtask

  task automatic test_clamp();
    int n, b0, d0, r0, bad_addr, bad_data, bad_cyc, n_last;
    bit ok;
    data_base = 64'h100; tready = 1'b1;
    b0 = n_beats; d0 = n_done; r0 = n_reads;
    len = 10'd1023; ready = 1'b1; n = cyc;
    wait_done(d0, 700, ok);
    ready = 1'b0;
    bad_addr = 0; bad_data = 0; bad_cyc = 0; n_last = 0;
    for (int i = 0; i < 512; i++) begin
      if (read_addr[r0+i] != i) bad_addr++;
      if (beat_data[b0+i] !== 64'h100 + 64'(i)) bad_data++;
      if (beat_cyc[b0+i] != n + 3 + i) bad_cyc++;
      if (beat_last[b0+i]) n_last++;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clamp_done_timeout got=%0b exp=1", ok); end
    checks++; if (n_reads - r0 !== 512) begin errors++; $display("FAIL clamp_reads got=%0d exp=512", n_reads - r0); end
    checks++; if (n_beats - b0 !== 512) begin errors++; $display("FAIL clamp_beats got=%0d exp=512", n_beats - b0); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL clamp_addr_seq got=%0d_bad exp=0", bad_addr); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL clamp_data got=%0d_bad exp=0", bad_data); end
    checks++; if (bad_cyc !== 0)  begin errors++; $display("FAIL clamp_throughput got=%0d_bad exp=0", bad_cyc); end
    checks++; if (n_last !== 1 || beat_last[b0+511] !== 1'b1) begin
      errors++; $display("FAIL clamp_tlast got=count:%0d,idx511:%0b exp=1,1", n_last, beat_last[b0+511]);
    end
    checks++; if (done_cyc[d0] !== n + 515) begin errors++; $display("FAIL clamp_done_cycle got=%0d exp=%0d", done_cyc[d0], n + 515); end
    step(2);
  endtask

  task automatic test_back_to_back();
    int n, b0, d0;
    bit ok1, ok2;
    logic [DW-1:0] exp_data [5];
    bit            exp_last [5];
    exp_data = '{64'h200, 64'h201, 64'h202, 64'h300, 64'h301};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    data_base = 64'h200; tready = 1'b1;
    b0 = n_beats; d0 = n_done;
    len = 10'd3; ready = 1'b1; n = cyc;
    wait_done(d0, 40, ok1);
    len = 10'd2; data_base = 64'h300;
    wait_done(d0 + 1, 40, ok2);
    ready = 1'b0;
    step(3);
    checks++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin errors++; $display("FAIL b2b_done_timeout got=%0b%0b exp=11", ok1, ok2); end
    checks++; if (n_beats - b0 !== 5) begin errors++; $display("FAIL b2b_beats got=%0d exp=5", n_beats - b0); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (beat_data[b0+i] !== exp_data[i] || beat_last[b0+i] !== exp_last[i]) begin
        errors++; $display("FAIL b2b_beat[%0d] got=%0h/%0b exp=%0h/%0b", i, beat_data[b0+i], beat_last[b0+i],
                           exp_data[i], exp_last[i]);
      end
    end
    checks++; if (beat_cyc[b0+2] !== n + 5) begin errors++; $display("FAIL b2b_tlast_cycle got=%0d exp=%0d", beat_cyc[b0+2], n + 5); end
    checks++; if (done_cyc[d0] !== n + 6) begin errors++; $display("FAIL b2b_done1_cycle got=%0d exp=%0d", done_cyc[d0], n + 6); end
    checks++; if (beat_cyc[b0+3] !== n + 11) begin errors++; $display("FAIL b2b_gap got=%0d exp=%0d", beat_cyc[b0+3], n + 11); end
    checks++; if (done_cyc[d0+1] !== n + 13) begin errors++; $display("FAIL b2b_done2_cycle got=%0d exp=%0d", done_cyc[d0+1], n + 13); end
    checks++; if (n_done - d0 !== 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=2", n_done - d0); end
    checks++; if (pkt_count !== 32'd6) begin errors++; $display("FAIL b2b_pkt_count got=%0d exp=6", pkt_count); end
  endtask

  task automatic test_reset_mid();
    int n, b0, b1, d0, k;
    bit ok;
    data_base = 64'h100; tready = 1'b1;
    b0 = n_beats; d0 = n_done;
    len = 10'd8; ready = 1'b1;
    k = 0;
    while (n_beats - b0 < 3 && k < 30) begin
      step();
      k++;
    end
    checks++; if (n_beats - b0 !== 3) begin errors++; $display("FAIL rmid_pre_beats got=%0d exp=3", n_beats - b0); end
    rst_n = 1'b0; ready = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0 || tdata !== '0 || tlast !== 1'b0) begin
      errors++; $display("FAIL rmid_stream_cleared got=%0b/%0h/%0b exp=0/0/0", tvalid, tdata, tlast);
    end
    checks++; if (rd_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl_cleared got=%0b/%0b exp=0/0", rd_en, done);
    end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL rmid_pkt_count got=%0d exp=0", pkt_count); end
    step(3);
    rst_n = 1'b1;
    step(3);
    checks++; if (n_done - d0 !== 0 || pkt_count !== 32'd0) begin
      errors++; $display("FAIL rmid_no_done got=%0d/%0d exp=0/0", n_done - d0, pkt_count);
    end
    data_base = 64'h400;
    b1 = n_beats;
    len = 10'd2; ready = 1'b1; n = cyc;
    wait_done(d0, 30, ok);
    ready = 1'b0;
    step(2);
    checks++; if (ok !== 1'b1 || n_beats - b1 !== 2) begin
      errors++; $display("FAIL rmid_len2 got=done:%0b,beats:%0d exp=1,2", ok, n_beats - b1);
    end
    checks++; if (beat_data[b1] !== 64'h400 || beat_data[b1+1] !== 64'h401) begin
      errors++; $display("FAIL rmid_len2_data got=%0h,%0h exp=400,401", beat_data[b1], beat_data[b1+1]);
    end
    checks++; if (beat_last[b1] !== 1'b0 || beat_last[b1+1] !== 1'b1) begin
      errors++; $display("FAIL rmid_len2_tlast got=%0b%0b exp=01", beat_last[b1], beat_last[b1+1]);
    end
    checks++; if (beat_cyc[b1] !== n + 3) begin errors++; $display("FAIL rmid_len2_latency got=%0d exp=%0d", beat_cyc[b1], n + 3); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL rmid_len2_pkt_count got=%0d exp=1", pkt_count); end
  endtask

  initial begin
    rst_n = 1'b1; ready = 1'b0; len = '0; tready = 1'b0; data_base = '0;
    test_reset();
    test_len4();
    test_backpressure();
    test_zero_len();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=time_expired exp=finish");
    $fatal(1, "bench timeout");
  end

endmodule
